// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Width defines fall back to RV32 values when the global defines are absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        VLD,
        HALT,
        ERR
    } ifu_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ifu_pc_reg.sv
// PC register: sequential-or-redirect next PC, plus redirect alignment check.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   advance,
    input  logic                   jmp_en,
    input  logic [`ADDR_WIDTH-1:0] jmp_pc,
    output logic [`ADDR_WIDTH-1:0] pc,
    output logic                   misaligned
);

    logic [`ADDR_WIDTH-1:0] pc_next;

    always_comb begin
        pc_next    = jmp_en ? jmp_pc : pc + `ADDR_WIDTH'(PC_STEP);
        misaligned = jmp_en && (jmp_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: one outstanding RAM fetch, 1-entry buffer to decode,
// redirect on handshake, sticky halt on ebreak and sticky error on fetch faults.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [`ADDR_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned            TIMEOUT   = 16,
    parameter int unsigned            CNT_WIDTH = 32
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_rst,
    output logic                   o_ifu_ram_req,
    output logic [`ADDR_WIDTH-1:0] o_ifu_ram_addr,
    input  logic                   i_ram_rsp_valid,
    input  logic [`INST_WIDTH-1:0] i_ram_rsp_inst,
    input  logic                   i_ram_rsp_err,
    output logic                   o_sys_valid,
    input  logic                   i_sys_ready,
    output logic [`INST_WIDTH-1:0] o_ifu_inst,
    output logic [`ADDR_WIDTH-1:0] o_ifu_pc,
    input  logic                   i_exu_jmp_en,
    input  logic [`ADDR_WIDTH-1:0] i_exu_jmp_pc,
    input  logic                   i_idu_end_flag,
    output logic                   o_ifu_halt,
    output logic                   o_ifu_err,
    output logic [CNT_WIDTH-1:0]   o_ifu_inst_cnt
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    ifu_state_e             state;
    logic [`INST_WIDTH-1:0] inst_buf;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [`ADDR_WIDTH-1:0] pc;
    logic                   misaligned;
    logic                   hs;
    logic                   pc_advance;

    assign hs = o_sys_valid && i_sys_ready;
    // End flag takes priority, so its PC update happens even with a misaligned target.
    assign pc_advance = hs && (i_idu_end_flag || !misaligned);

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (i_sys_clk),
        .rst        (i_sys_rst),
        .advance    (pc_advance),
        .jmp_en     (i_exu_jmp_en),
        .jmp_pc     (i_exu_jmp_pc),
        .pc         (pc),
        .misaligned (misaligned)
    );

    assign o_ifu_pc       = pc;
    assign o_ifu_inst     = inst_buf;
    assign o_ifu_ram_addr = o_ifu_ram_req ? pc : '0;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state          <= IDLE;
            inst_buf       <= '0;
            wait_cnt       <= '0;
            o_ifu_ram_req  <= 1'b0;
            o_sys_valid    <= 1'b0;
            o_ifu_halt     <= 1'b0;
            o_ifu_err      <= 1'b0;
            o_ifu_inst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= REQ;
                    o_ifu_ram_req <= 1'b1;
                    wait_cnt      <= '0;
                end
                REQ: begin
                    if (i_ram_rsp_valid) begin
                        o_ifu_ram_req <= 1'b0;
                        if (i_ram_rsp_err) begin
                            state     <= ERR;
                            o_ifu_err <= 1'b1;
                        end else begin
                            inst_buf    <= i_ram_rsp_inst;
                            state       <= VLD;
                            o_sys_valid <= 1'b1;
                        end
                    end else if (TIMEOUT != 0 && wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        o_ifu_ram_req <= 1'b0;
                        state         <= ERR;
                        o_ifu_err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                VLD: begin
                    if (hs) begin
                        o_ifu_inst_cnt <= o_ifu_inst_cnt + CNT_WIDTH'(1);
                        o_sys_valid    <= 1'b0;
                        if (i_idu_end_flag) begin
                            state      <= HALT;
                            o_ifu_halt <= 1'b1;
                        end else if (misaligned) begin
                            state     <= ERR;
                            o_ifu_err <= 1'b1;
                        end else begin
                            state         <= REQ;
                            o_ifu_ram_req <= 1'b1;
                            wait_cnt      <= '0;
                        end
                    end
                end
                HALT, ERR: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
